endstop_event_arbiter: RTL

- Sequences a bank of debounce channels (limit switches, probe, filament sensors) and serialises their latched transitions into one valid/ready event stream for the CPU bus bridge.
- Round-robin arbitration between channels.
- Returns each channel to unlocked state after its event is consumed.
- Raises a sticky motion-stop request for channels marked as stopping.

---
 rtl/endstop_event_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/endstop_event_arbiter.sv
// endstop_event_arbiter
// Serialises latched transitions from a bank of debounce channels into a
// single valid/ready event stream. Channels are served round-robin. After
// each event is consumed, the channel is handed back to its debouncer with
// a one-cycle unlock pulse. Stopping channels raise a sticky motion-stop
// request.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | scanning candidates from the round-robin pointer
// PRESENT | payload registered, evt_valid high, waiting for evt_ready
// UNLOCK  | one-cycle ch_unlock pulse to the served channel
// DRAIN   | waiting for the served channel's changed flag to fall
module endstop_event_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    ch_changed,
  input  logic [CHANNELS-1:0]    ch_sig,
  input  logic [32*CHANNELS-1:0] ch_pos,
  input  logic [8*CHANNELS-1:0]  ch_cycles,
  output logic [CHANNELS-1:0]    ch_unlock,
  input  logic [CHANNELS-1:0]    enable_mask,
  input  logic [CHANNELS-1:0]    stop_mask,
  input  logic                   stop_clear,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CH_W-1:0]        evt_channel,
  output logic                   evt_value,
  output logic [31:0]            evt_pos,
  output logic [7:0]             evt_cycles,
  output logic                   stop_req,
  output logic [15:0]            evt_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_UNLOCK  = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_idx;
  logic                r_value;
  logic [31:0]         r_pos;
  logic [7:0]          r_cycles;
  logic                r_stop;
  logic [15:0]         r_count;

  logic [CHANNELS-1:0] w_cand;
  logic                w_any;
  logic [CH_W-1:0]     w_sel;
  logic                w_sel_sig;
  logic [31:0]         w_sel_pos;
  logic [7:0]          w_sel_cyc;
  logic                w_sel_stop;
  logic                w_take;
  logic                w_hand;
  logic                w_drain_done;
  logic [CH_W-1:0]     w_ptr_nxt;

  assign w_cand = ch_changed & enable_mask;

  // Round-robin pick: first candidate at or above the pointer, with wrap.
  always_comb begin
    int j;
    j          = 0;
    w_any      = 1'b0;
    w_sel      = '0;
    w_sel_sig  = 1'b0;
    w_sel_pos  = '0;
    w_sel_cyc  = '0;
    w_sel_stop = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(r_ptr) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!w_any && w_cand[j]) begin
        w_any      = 1'b1;
        w_sel      = CH_W'(j);
        w_sel_sig  = ch_sig[j];
        w_sel_pos  = ch_pos[32*j +: 32];
        w_sel_cyc  = ch_cycles[8*j +: 8];
        w_sel_stop = stop_mask[j] & ch_sig[j];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and the strobes that steer the datapath registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_hand       = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_take      = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (evt_ready) begin
          w_hand      = 1'b1;
          w_state_nxt = S_UNLOCK;
        end
      end
      S_UNLOCK: begin
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // A re-latched transition keeps the flag high; hold here until
        // software unlocks the channel directly.
        if (!ch_changed[r_idx]) begin
          w_drain_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ptr_nxt = (r_idx == CH_W'(CHANNELS - 1)) ? '0 : r_idx + CH_W'(1);

  // Payload capture and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_idx    <= '0;
      r_value  <= 1'b0;
      r_pos    <= '0;
      r_cycles <= '0;
    end else begin
      if (w_take) begin
        r_idx    <= w_sel;
        r_value  <= w_sel_sig;
        r_pos    <= w_sel_pos;
        r_cycles <= w_sel_cyc;
      end
      if (w_drain_done) r_ptr <= w_ptr_nxt;
    end
  end

  // Sticky stop request; a qualifying capture wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                   r_stop <= 1'b0;
    else if (w_take && w_sel_stop) r_stop <= 1'b1;
    else if (stop_clear)         r_stop <= 1'b0;
  end

  // Handed-off event counter, free-running modulo 2^16.
  always_ff @(posedge clk) begin
    if (reset)       r_count <= '0;
    else if (w_hand) r_count <= r_count + 16'd1;
  end

  // Unlock pulse is decoded from state so it lasts exactly one cycle.
  always_comb begin
    ch_unlock = '0;
    if (r_state == S_UNLOCK) ch_unlock[r_idx] = 1'b1;
  end

  assign evt_valid   = (r_state == S_PRESENT);
  assign busy        = (r_state != S_IDLE);
  assign evt_channel = r_idx;
  assign evt_value   = r_value;
  assign evt_pos     = r_pos;
  assign evt_cycles  = r_cycles;
  assign stop_req    = r_stop;
  assign evt_count   = r_count;

endmodule
